serial_datapath: RTL

Bit-serial execution datapath driven by the CPU control FSM's strobes (register read, immediate shift, execute, accumulator write) for each instruction phase.
- Holds the register file, operand shift registers, serial ALU with carry, accumulator and bit counter.
- Returns bit_done to the FSM to close each WIDTH-cycle phase.
- Sits between the control FSM and the top-level I/O; a parallel preload port initialises registers.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/serial_alu_bit.sv | 48 ++++
 rtl/serial_datapath.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the bit-serial CPU: ALU operation codes, datapath
// defaults and the opcode set decoded by the control FSM.
package cpu_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NREGS_DEF = 8;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_ADDI = 3'd2,
        OP_XOR  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5
    } opcode_e;

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit ALU slice for the serial datapath. Sum/logic output and carry-out
// are combinational; the carry register feeds the next bit.
module serial_alu_bit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       step_en,
    input  logic       carry_en,
    input  logic       cin_sel,
    input  logic       sub_en,
    input  logic [1:0] alu_op,
    input  logic       a,
    input  logic       b,
    output logic       s,
    output logic       cout
);

    logic carry_reg;
    logic b_eff;
    logic cin;

    // First bit of a phase takes its carry-in from sub_en (1 for two's complement)
    assign cin   = cin_sel ? sub_en : carry_reg;
    assign b_eff = b ^ sub_en;
    assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

    always_comb begin
        s = 1'b0;
        case (alu_op)
            ALU_ADD: s = a ^ b_eff ^ cin;
            ALU_XOR: s = a ^ b;
            ALU_AND: s = a & b;
            ALU_OR:  s = a | b;
            default: s = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            carry_reg <= 1'b0;
        end else if (step_en && carry_en) begin
            carry_reg <= cout;
        end
    end

endmodule

// File: rtl/serial_datapath.sv
// Bit-serial execution datapath: register file, operand shifters, serial ALU,
// result/accumulator shifters and the phase bit counter.
module serial_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_counter,
    input  logic             en_counter,
    input  logic             reg_read_en,
    input  logic [2:0]       reg_addr_sel,
    input  logic             reg_write_en,
    input  logic             imm_shift_en,
    input  logic             exec_en,
    input  logic             sub_en,
    input  logic [1:0]       alu_op,
    input  logic             carry_en,
    input  logic             acc_write_en,
    input  logic             acc_shift_en,
    input  logic             imm_load,
    input  logic [6:0]       imm_in,
    input  logic             ld_en,
    input  logic [2:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic             bit_done,
    output logic [WIDTH-1:0] acc_out,
    output logic             carry_flag,
    output logic             zero_flag
);

    logic [CNT_W-1:0] cnt_reg;
    logic             read_phase_reg;
    logic [WIDTH-1:0] regs_reg [NREGS];
    logic [WIDTH-1:0] op_a_reg, op_b_reg, imm_reg, result_reg, acc_reg;
    logic             carry_flag_reg;

    logic [NREGS-1:0] ser_hit;
    logic [NREGS-1:0] ld_hit;
    logic             rd_bit;
    logic             wr_shift;
    logic             alu_s, alu_cout;
    logic             last_bit;

    assign last_bit   = (cnt_reg == CNT_W'(WIDTH - 1));
    assign bit_done   = en_counter && last_bit && !clr_counter;
    assign wr_shift   = acc_write_en && acc_shift_en;
    assign rd_bit     = regs_reg[reg_addr_sel][0];
    assign acc_out    = acc_reg;
    assign carry_flag = carry_flag_reg;
    assign zero_flag  = (acc_reg == '0);

    // A preload loses to any serial access aimed at the same register
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_hit
        assign ser_hit[gi] = (reg_addr_sel == 3'(gi));
        assign ld_hit[gi]  = ld_en && (ld_addr == 3'(gi)) &&
                             !((reg_read_en || reg_write_en) && ser_hit[gi]);
    end

    always_ff @(posedge clk) begin
        if (rst || clr_counter) begin
            cnt_reg <= '0;
        end else if (en_counter) begin
            cnt_reg <= last_bit ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_counter) begin
            read_phase_reg <= 1'b0;
        end else if (reg_read_en && bit_done) begin
            read_phase_reg <= ~read_phase_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_read_en && ser_hit[i]) begin
                    regs_reg[i] <= {regs_reg[i][0], regs_reg[i][WIDTH-1:1]};
                end else if (wr_shift && reg_write_en && ser_hit[i]) begin
                    regs_reg[i] <= {result_reg[0], regs_reg[i][WIDTH-1:1]};
                end else if (ld_hit[i]) begin
                    regs_reg[i] <= ld_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_reg <= '0;
            op_b_reg <= '0;
            imm_reg  <= '0;
        end else begin
            if (reg_read_en && !read_phase_reg)
                op_a_reg <= {rd_bit, op_a_reg[WIDTH-1:1]};
            else if (exec_en)
                op_a_reg <= {1'b0, op_a_reg[WIDTH-1:1]};

            if (reg_read_en && read_phase_reg)
                op_b_reg <= {rd_bit, op_b_reg[WIDTH-1:1]};
            else if (imm_shift_en)
                op_b_reg <= {imm_reg[0], op_b_reg[WIDTH-1:1]};
            else if (exec_en)
                op_b_reg <= {1'b0, op_b_reg[WIDTH-1:1]};

            if (imm_load)
                imm_reg <= {{(WIDTH-7){1'b0}}, imm_in};
            else if (imm_shift_en && !reg_read_en)
                imm_reg <= {imm_reg[0], imm_reg[WIDTH-1:1]};
        end
    end

    serial_alu_bit u_alu (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_counter),
        .step_en  (exec_en),
        .carry_en (carry_en),
        .cin_sel  (cnt_reg == '0),
        .sub_en   (sub_en),
        .alu_op   (alu_op),
        .a        (op_a_reg[0]),
        .b        (op_b_reg[0]),
        .s        (alu_s),
        .cout     (alu_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg     <= '0;
            acc_reg        <= '0;
            carry_flag_reg <= 1'b0;
        end else begin
            if (exec_en)
                result_reg <= {alu_s, result_reg[WIDTH-1:1]};
            else if (wr_shift)
                result_reg <= {result_reg[0], result_reg[WIDTH-1:1]};

            if (wr_shift)
                acc_reg <= {result_reg[0], acc_reg[WIDTH-1:1]};

            if (exec_en && bit_done)
                carry_flag_reg <= (alu_op == ALU_ADD) ? alu_cout : 1'b0;
        end
    end

endmodule
